// File: rtl/eth_pcs_pkg.sv
// eth_pcs_pkg: shared 10G PCS definitions.
//   SYNC_DATA / SYNC_CTRL  - the two legal 64b/66b sync headers
//   block_lock_state_t     - receive block-lock state encoding
//   *_DEF                  - default lock and BER constants
//   sync_hdr_valid()       - true for a legal sync header
package eth_pcs_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam int LOCK_COUNT_DEF       = 64;
   localparam int INVALID_LIMIT_DEF    = 16;
   localparam int SLIP_WAIT_CYCLES_DEF = 32;
   localparam int BER_WINDOW_DEF       = 20141;
   localparam int BER_LIMIT_DEF        = 16;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SLIP   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_LOCKED = 2'd3
   } block_lock_state_t;

   function automatic logic sync_hdr_valid(input logic [1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/rx_ber_monitor.sv
// rx_ber_monitor: counts invalid sync headers per BER window while locked.
//   clk     - receive clock
//   rst     - asynchronous active-high reset
//   locked  - block lock held for this cycle and the next; low clears everything
//   inv_hdr - qualified invalid header strobe
//   hi_ber  - high bit-error-rate flag (registered)
module rx_ber_monitor
   import eth_pcs_pkg::*;
#(
   parameter int BER_WINDOW = BER_WINDOW_DEF,
   parameter int BER_LIMIT  = BER_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic locked,
   input  logic inv_hdr,
   output logic hi_ber
);

   localparam int TW = $clog2(BER_WINDOW + 1);
   localparam int CW = $clog2(BER_LIMIT + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(BER_WINDOW - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(BER_LIMIT);

   logic [TW-1:0] tmr;
   logic [CW-1:0] ber_cnt;

   // Timer is a down-counter; reaching zero marks the last cycle of a window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr     <= TMR_LOAD;
         ber_cnt <= '0;
         hi_ber  <= 1'b0;
      end else if (!locked) begin
         tmr     <= TMR_LOAD;
         ber_cnt <= '0;
         hi_ber  <= 1'b0;
      end else if (tmr == '0) begin
         tmr     <= TMR_LOAD;
         ber_cnt <= '0;
         hi_ber  <= (ber_cnt == CNT_MAX);
      end else begin
         tmr <= tmr - TW'(1);
         if (ber_cnt == CNT_MAX)
            hi_ber <= 1'b1;
         else if (inv_hdr)
            ber_cnt <= ber_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b/66b receive block synchronisation with BER monitor.
//   xver_rx_clk           - receive clock
//   i_rx_reset            - asynchronous active-high reset
//   xver_rx_header        - sync header of the current block
//   xver_rx_gearbox_valid - header qualifier
//   xver_rx_gearbox_slip  - one-cycle slip request to the gearbox
//   o_block_lock          - header alignment achieved
//   o_hi_ber              - high bit-error-rate indication
//
// state     | meaning
// ST_HUNT   | counting consecutive valid headers toward lock
// ST_SLIP   | one-cycle slip pulse to the gearbox
// ST_WAIT   | headers ignored while the gearbox settles
// ST_LOCKED | aligned; invalid headers counted per lock window
module rx_block_lock
   import eth_pcs_pkg::*;
#(
   parameter int LOCK_COUNT       = LOCK_COUNT_DEF,
   parameter int INVALID_LIMIT    = INVALID_LIMIT_DEF,
   parameter int SLIP_WAIT_CYCLES = SLIP_WAIT_CYCLES_DEF,
   parameter int BER_WINDOW       = BER_WINDOW_DEF,
   parameter int BER_LIMIT        = BER_LIMIT_DEF
) (
   input  logic       xver_rx_clk,
   input  logic       i_rx_reset,
   input  logic [1:0] xver_rx_header,
   input  logic       xver_rx_gearbox_valid,
   output logic       xver_rx_gearbox_slip,
   output logic       o_block_lock,
   output logic       o_hi_ber
);

   localparam int SW = $clog2(LOCK_COUNT + 1);
   localparam int IW = $clog2(INVALID_LIMIT + 1);
   localparam int WW = $clog2(SLIP_WAIT_CYCLES + 1);
   localparam logic [SW-1:0] SH_TC     = SW'(LOCK_COUNT);
   localparam logic [IW-1:0] INV_TC    = IW'(INVALID_LIMIT);
   localparam logic [WW-1:0] WAIT_LOAD = WW'(SLIP_WAIT_CYCLES - 1);

   block_lock_state_t state, state_nxt;
   logic [SW-1:0] sh_cnt, sh_cnt_nxt, sh_inc;
   logic [IW-1:0] inv_cnt, inv_cnt_nxt, inv_inc;
   logic [WW-1:0] wait_cnt, wait_cnt_nxt;
   logic          hdr_ok;
   logic          ber_run;
   logic          ber_inv;

   assign hdr_ok  = sync_hdr_valid(xver_rx_header);
   assign sh_inc  = sh_cnt + SW'(1);
   assign inv_inc = inv_cnt + IW'(!hdr_ok);

   always_comb begin
      state_nxt    = state;
      sh_cnt_nxt   = sh_cnt;
      inv_cnt_nxt  = inv_cnt;
      wait_cnt_nxt = wait_cnt;
      case (state)
         ST_HUNT: begin
            if (xver_rx_gearbox_valid) begin
               if (!hdr_ok) begin
                  state_nxt  = ST_SLIP;
                  sh_cnt_nxt = '0;
               end else if (sh_inc == SH_TC) begin
                  state_nxt   = ST_LOCKED;
                  sh_cnt_nxt  = '0;
                  inv_cnt_nxt = '0;
               end else begin
                  sh_cnt_nxt = sh_inc;
               end
            end
         end
         ST_SLIP: begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
         end
         ST_WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt  = ST_HUNT;
               sh_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt - WW'(1);
            end
         end
         ST_LOCKED: begin
            if (xver_rx_gearbox_valid) begin
               // Limit check comes first so loss of lock wins on a window's last block.
               if (inv_inc == INV_TC) begin
                  state_nxt   = ST_SLIP;
                  sh_cnt_nxt  = '0;
                  inv_cnt_nxt = '0;
               end else if (sh_inc == SH_TC) begin
                  sh_cnt_nxt  = '0;
                  inv_cnt_nxt = '0;
               end else begin
                  sh_cnt_nxt  = sh_inc;
                  inv_cnt_nxt = inv_inc;
               end
            end
         end
         default: state_nxt = ST_HUNT;
      endcase
   end

   // Outputs come from next-state decode so they are flops aligned with the state.
   always_ff @(posedge xver_rx_clk or posedge i_rx_reset) begin
      if (i_rx_reset) begin
         state                <= ST_HUNT;
         sh_cnt               <= '0;
         inv_cnt              <= '0;
         wait_cnt             <= '0;
         xver_rx_gearbox_slip <= 1'b0;
         o_block_lock         <= 1'b0;
      end else begin
         state                <= state_nxt;
         sh_cnt               <= sh_cnt_nxt;
         inv_cnt              <= inv_cnt_nxt;
         wait_cnt             <= wait_cnt_nxt;
         xver_rx_gearbox_slip <= (state_nxt == ST_SLIP);
         o_block_lock         <= (state_nxt == ST_LOCKED);
      end
   end

   // Leaving LOCKED clears the monitor on the same edge that drops lock.
   assign ber_run = (state == ST_LOCKED) && (state_nxt == ST_LOCKED);
   assign ber_inv = (state == ST_LOCKED) && xver_rx_gearbox_valid && !hdr_ok;

   rx_ber_monitor #(
      .BER_WINDOW (BER_WINDOW),
      .BER_LIMIT  (BER_LIMIT)
   ) u_ber (
      .clk     (xver_rx_clk),
      .rst     (i_rx_reset),
      .locked  (ber_run),
      .inv_hdr (ber_inv),
      .hi_ber  (o_hi_ber)
   );

endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock: directed bench for rx_block_lock with a reference model
// feeding an expected-output queue each cycle.
module tb_rx_block_lock;

   localparam int LOCK_COUNT       = 64;
   localparam int INVALID_LIMIT    = 16;
   localparam int SLIP_WAIT_CYCLES = 32;
   localparam int BER_WINDOW       = 100;
   localparam int BER_LIMIT        = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] hdr;
   logic       vld;
   logic       slip;
   logic       lock;
   logic       hi;

   always #5 clk = ~clk;

   rx_block_lock #(
      .LOCK_COUNT       (LOCK_COUNT),
      .INVALID_LIMIT    (INVALID_LIMIT),
      .SLIP_WAIT_CYCLES (SLIP_WAIT_CYCLES),
      .BER_WINDOW       (BER_WINDOW),
      .BER_LIMIT        (BER_LIMIT)
   ) dut (
      .xver_rx_clk           (clk),
      .i_rx_reset            (rst),
      .xver_rx_header        (hdr),
      .xver_rx_gearbox_valid (vld),
      .xver_rx_gearbox_slip  (slip),
      .o_block_lock          (lock),
      .o_hi_ber              (hi)
   );

   typedef struct packed {
      logic slip;
      logic lock;
      logic hi;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   slip_seen = 0;
   logic prev_slip = 1'b0;

   // reference model: 0 hunt, 1 slip, 2 wait, 3 locked
   int m_state, m_sh, m_inv, m_wait, m_tmr, m_ber;
   bit m_hi;

   task automatic check(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_sh = 0; m_inv = 0; m_wait = 0; m_tmr = 0; m_ber = 0; m_hi = 0;
   endtask

   task automatic model_step(input logic [1:0] h, input logic v);
      bit good;
      int ns;
      good = (h == 2'b01) || (h == 2'b10);
      ns = m_state;
      case (m_state)
         0: if (v) begin
               if (!good) begin
                  ns = 1; m_sh = 0;
               end else begin
                  m_sh++;
                  if (m_sh == LOCK_COUNT) begin ns = 3; m_sh = 0; m_inv = 0; end
               end
            end
         1: begin ns = 2; m_wait = 0; end
         2: begin
               m_wait++;
               if (m_wait == SLIP_WAIT_CYCLES) begin ns = 0; m_sh = 0; end
            end
         default: if (v) begin
               m_sh++;
               if (!good) m_inv++;
               if (m_inv == INVALID_LIMIT) begin ns = 1; m_sh = 0; m_inv = 0; end
               else if (m_sh == LOCK_COUNT) begin m_sh = 0; m_inv = 0; end
            end
      endcase
      if (m_state == 3 && ns == 3) begin
         if (m_tmr == BER_WINDOW - 1) begin
            m_hi = (m_ber == BER_LIMIT); m_ber = 0; m_tmr = 0;
         end else begin
            if (m_ber == BER_LIMIT) m_hi = 1;
            if (v && !good && m_ber < BER_LIMIT) m_ber++;
            m_tmr++;
         end
      end else begin
         m_tmr = 0; m_ber = 0; m_hi = 0;
      end
      m_state = ns;
   endtask

   task automatic step(input logic [1:0] h, input logic v);
      exp_t e;
      hdr = h;
      vld = v;
      model_step(h, v);
      e.slip = (m_state == 1);
      e.lock = (m_state == 3);
      e.hi   = m_hi;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("slip", slip, e.slip);
      check("lock", lock, e.lock);
      check("hi_ber", hi, e.hi);
      check("slip_back_to_back", slip && prev_slip, 1'b0);
      if (slip) slip_seen++;
      prev_slip = slip;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hdr = 2'b00;
      vld = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_slip", slip, 1'b0);
      check("rst_lock", lock, 1'b0);
      check("rst_hi_ber", hi, 1'b0);
      rst = 1'b0;
      prev_slip = 1'b0;
      slip_seen = 0;
   endtask

   function automatic logic [1:0] good_hdr(input int n);
      return (n % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   initial begin
      int q;
      logic [1:0] h;
      rst = 1'b1;
      hdr = 2'b00;
      vld = 1'b0;
      model_reset();

      // clean lock
      do_reset();
      for (int i = 0; i < LOCK_COUNT; i++) begin
         step(good_hdr(i), 1'b1);
         if (i == LOCK_COUNT - 2) check("clean_not_yet_locked", lock, 1'b0);
      end
      check("clean_locked", lock, 1'b1);
      check("clean_no_slip", slip_seen == 0, 1'b1);

      // hunt slip at block 10, 00 headers ignored through SLIP + WAIT, then relock
      do_reset();
      for (int i = 0; i < 9; i++) step(good_hdr(i), 1'b1);
      step(2'b11, 1'b1);
      check("hunt_slip_pulse", slip, 1'b1);
      for (int i = 0; i < SLIP_WAIT_CYCLES + 1; i++) step(2'b00, 1'b1);
      check("hunt_single_slip", slip_seen == 1, 1'b1);
      for (int i = 0; i < LOCK_COUNT; i++) step(good_hdr(i), 1'b1);
      check("hunt_relocked", lock, 1'b1);
      check("hunt_slips_total", slip_seen == 1, 1'b1);

      // 15 invalid per lock window holds lock
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < LOCK_COUNT; i++)
            step((i % 4 == 0 && i < 60) ? 2'b00 : good_hdr(i), 1'b1);
         check("window15_lock_held", lock, 1'b1);
      end
      check("window15_no_slip", slip_seen == 1, 1'b1);

      // 16 invalid among 40 blocks drops lock with a slip
      for (int i = 0; i < 40; i++) begin
         step((i % 2 == 0 && i < 32) ? 2'b11 : good_hdr(i), 1'b1);
         if (i == 30) begin
            check("loss_lock_low", lock, 1'b0);
            check("loss_slip_high", slip, 1'b1);
         end
      end

      // valid gating: every 33rd cycle unqualified carrying 11
      do_reset();
      q = 0;
      for (int c = 1; c < 200 && q < LOCK_COUNT; c++) begin
         if (c % 33 == 0) step(2'b11, 1'b0);
         else begin
            step(good_hdr(q), 1'b1);
            q++;
         end
      end
      check("gate_locked", lock, 1'b1);
      check("gate_no_slip", slip_seen == 0, 1'b1);

      // hi BER with BER_WINDOW=100; third window clean
      do_reset();
      for (int i = 0; i < LOCK_COUNT; i++) step(good_hdr(i), 1'b1);
      for (int k = 0; k < 400; k++) begin
         h = ((k / 100) != 2 && (k % 100) % 6 == 3 && (k % 100) < 96) ? 2'b00 : good_hdr(k);
         step(h, 1'b1);
         if (k == 92)  check("ber_before_16th", hi, 1'b0);
         if (k == 95)  check("ber_set", hi, 1'b1);
         if (k == 205) check("ber_held_next_window", hi, 1'b1);
         if (k == 298) check("ber_held_clean_window", hi, 1'b1);
         if (k == 299) check("ber_cleared", hi, 1'b0);
      end
      check("ber_lock_kept", lock, 1'b1);
      check("ber_set_again", hi, 1'b1);

      // asynchronous reset while locked with hi_ber set
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_slip", slip, 1'b0);
      check("async_rst_lock", lock, 1'b0);
      check("async_rst_hi_ber", hi, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev_slip = 1'b0;
      step(2'b00, 1'b1);
      check("after_rst_hunt_slip", slip, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
